// File: rtl/uart_program_loader.sv
// Packs UART receiver bytes into memory words (LSB byte first) and writes them to
// consecutive instruction-memory addresses until a halt word, address overflow or timeout.
module uart_program_loader #(
  parameter int unsigned       D_BIT         = 8,
  parameter int unsigned       WORD_BYTES    = 4,
  parameter int unsigned       ADDR_W        = 10,
  parameter logic [15:0]       TIMEOUT_TICKS = 16'd40000,
  parameter int unsigned       WORD_W        = D_BIT * WORD_BYTES,
  parameter logic [WORD_W-1:0] HALT_WORD     = {WORD_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_tick,
  input  logic              rx_done,
  input  logic [D_BIT-1:0]  d_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_WAIT  = 5'b00010,
    S_WRITE = 5'b00100,
    S_DONE  = 5'b01000,
    S_ERROR = 5'b10000
  } state_t;

  state_t            state_q, state_d;
  logic              rx_done_q, rx_done_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [15:0]       timer_q, timer_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              error_q, error_d;

  logic rx_ev;
  logic take_byte;
  logic word_full;

  always_comb begin
    state_d      = state_q;
    rx_done_d    = rx_done;
    byte_idx_d   = byte_idx_q;
    timer_d      = timer_q;
    shift_d      = shift_q;
    mem_wdata_d  = mem_wdata_q;
    mem_addr_d   = mem_addr_q;
    word_count_d = word_count_q;

    rx_ev     = rx_done & ~rx_done_q;
    take_byte = rx_ev & ((state_q == S_WAIT) | (state_q == S_WRITE));
    word_full = 1'b0;

    // A byte arriving during the write cycle simply starts the next word.
    if (take_byte) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        if (byte_idx_q == IDX_W'(i)) begin
          shift_d[i*D_BIT +: D_BIT] = d_in;
        end
      end
      timer_d = '0;
      if (byte_idx_q == LAST_IDX) begin
        word_full  = 1'b1;
        byte_idx_d = '0;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d      = S_WAIT;
          mem_addr_d   = '0;
          word_count_d = '0;
          byte_idx_d   = '0;
          timer_d      = '0;
        end
      end
      S_WAIT: begin
        if (take_byte) begin
          if (word_full) begin
            mem_wdata_d = shift_d;
            state_d     = S_WRITE;
          end
        end else if (s_tick && (byte_idx_q != '0)) begin
          if (timer_q == TIMEOUT_TICKS - 16'd1) begin
            state_d = S_ERROR;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
      end
      S_WRITE: begin
        word_count_d = word_count_q + 1'b1;
        if (mem_wdata_q == HALT_WORD) begin
          state_d = S_DONE;
        end else if (mem_addr_q == MAX_ADDR) begin
          state_d = S_ERROR;
        end else begin
          mem_addr_d = mem_addr_q + 1'b1;
          state_d    = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_we_d    = (state_d == S_WRITE);
    busy_d      = (state_d == S_WAIT) | (state_d == S_WRITE);
    load_done_d = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rx_done_q    <= 1'b0;
      byte_idx_q   <= '0;
      timer_q      <= '0;
      shift_q      <= '0;
      mem_wdata_q  <= '0;
      mem_addr_q   <= '0;
      word_count_q <= '0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_done_q    <= rx_done_d;
      byte_idx_q   <= byte_idx_d;
      timer_q      <= timer_d;
      shift_q      <= shift_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_addr_q   <= mem_addr_d;
      word_count_q <= word_count_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      error_q      <= error_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized bench for uart_program_loader; expected writes come from a word-level model
// that packs the sent byte list and applies the halt / overflow end rules.
module tb_uart_program_loader;
  localparam int          ADDR_W = 2;
  localparam logic [15:0] TO     = 16'd100;
  localparam logic [31:0] HALT   = 32'hFFFFFFFF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              s_tick = 1'b0;
  logic              rx_done = 1'b0;
  logic [7:0]        d_in = 8'h00;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              load_done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  always #5 clk = ~clk;

  uart_program_loader #(.D_BIT(8), .WORD_BYTES(4), .ADDR_W(ADDR_W),
                        .TIMEOUT_TICKS(TO), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_tick(s_tick), .rx_done(rx_done),
    .d_in(d_in), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .load_done(load_done), .error(error), .word_count(word_count)
  );

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0]  prog_bytes[$];
  int          obs_addr[$];
  logic [31:0] obs_data[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done, exp_err;
  int          exp_count, exp_last;

  always @(negedge clk) begin
    if (mem_we) begin
      obs_addr.push_back(int'(mem_addr));
      obs_data.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    while (w == HALT) w = $urandom;
    return w;
  endfunction

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) prog_bytes.push_back(w[8*i +: 8]);
  endtask

  // Word-level reference: pack bytes LSB first, one write per word, stop at halt or last address.
  task automatic model_load();
    logic [31:0] w;
    exp_addr.delete(); exp_data.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_count = 0; exp_last = 0;
    for (int k = 0; 4*k + 3 < prog_bytes.size(); k++) begin
      w = {prog_bytes[4*k+3], prog_bytes[4*k+2], prog_bytes[4*k+1], prog_bytes[4*k]};
      exp_addr.push_back(k);
      exp_data.push_back(w);
      exp_count = k + 1;
      exp_last  = k;
      if (w == HALT) begin exp_done = 1'b1; break; end
      if (k == (1 << ADDR_W) - 1) begin exp_err = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; s_tick = 1'b0; rx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    obs_addr.delete(); obs_data.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int width, input int gap);
    d_in = b; rx_done = 1'b1;
    repeat (width) @(posedge clk);
    #1 rx_done = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      s_tick = 1'b1;
      @(posedge clk); #1;
      s_tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
    else n_pass++;
  endtask

  task automatic drive_program(input int width, input int gap_max);
    obs_addr.delete(); obs_data.delete();
    pulse_start();
    foreach (prog_bytes[i]) send_byte(prog_bytes[i], width, int'($urandom_range(1, gap_max)));
    wait_idle(400);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({mem_we, busy, load_done, error} !== 4'b0000)
      $display("[TB] FAIL reset_flags: got we/busy/done/err=%b required 0000", {mem_we, busy, load_done, error});
    else n_pass++;
    n_checks++;
    if (mem_addr !== '0 || word_count !== '0 || mem_wdata !== '0)
      $display("[TB] FAIL reset_regs: got addr=%0d cnt=%0d data=%h required 0", mem_addr, word_count, mem_wdata);
    else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    prog_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    model_load();
    drive_program(1, 3);
    n_checks++;
    if (obs_addr.size() !== exp_addr.size()) $display("[TB] FAIL basic_nwrites: got %0d required %0d", obs_addr.size(), exp_addr.size());
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("[TB] FAIL basic_write%0d: got %h@%0d required %h@%0d", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_data.size() > 0 && obs_data[0] !== 32'h12345678) $display("[TB] FAIL basic_word0: got %h required 12345678", obs_data[0]);
    else n_pass++;
    n_checks++;
    if ({load_done, error, busy} !== {exp_done, exp_err, 1'b0} || word_count !== 3'(exp_count) || mem_addr !== 2'(exp_last))
      $display("[TB] FAIL basic_status: got done/err/busy=%b cnt=%0d addr=%0d required %b%b0 cnt=%0d addr=%0d",
               {load_done, error, busy}, word_count, mem_addr, exp_done, exp_err, exp_count, exp_last);
    else n_pass++;
  endtask

  task automatic test_wide_rx();
    do_reset();
    prog_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    model_load();
    drive_program(20, 2);
    n_checks++;
    if (obs_addr.size() !== exp_addr.size()) $display("[TB] FAIL wide_nwrites: got %0d required %0d", obs_addr.size(), exp_addr.size());
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("[TB] FAIL wide_write%0d: got %h@%0d required %h@%0d", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
      else n_pass++;
    end
    n_checks++;
    if ({load_done, error} !== {exp_done, exp_err} || word_count !== 3'(exp_count))
      $display("[TB] FAIL wide_status: got done/err=%b cnt=%0d required %b%b cnt=%0d", {load_done, error}, word_count, exp_done, exp_err, exp_count);
    else n_pass++;
  endtask

  task automatic test_random_loads();
    int nw;
    for (int r = 0; r < 5; r++) begin
      do_reset();
      prog_bytes.delete();
      nw = int'($urandom_range(0, 3));
      for (int k = 0; k < nw; k++) add_word(rand_word());
      add_word(HALT);
      model_load();
      drive_program(int'($urandom_range(1, 4)), 3);
      n_checks++;
      if (obs_addr.size() !== exp_addr.size()) $display("[TB] FAIL rand%0d_nwrites: got %0d required %0d", r, obs_addr.size(), exp_addr.size());
      else n_pass++;
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        n_checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
          $display("[TB] FAIL rand%0d_write%0d: got %h@%0d required %h@%0d", r, i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
        else n_pass++;
      end
      n_checks++;
      if ({load_done, error} !== {exp_done, exp_err} || word_count !== 3'(exp_count) || mem_addr !== 2'(exp_last))
        $display("[TB] FAIL rand%0d_status: got done/err=%b cnt=%0d addr=%0d required %b%b cnt=%0d addr=%0d",
                 r, {load_done, error}, word_count, mem_addr, exp_done, exp_err, exp_count, exp_last);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    prog_bytes.delete();
    add_word(rand_word()); add_word(rand_word()); add_word(HALT);
    model_load();
    drive_program(1, 1);
    n_checks++;
    if (obs_addr.size() !== exp_addr.size()) $display("[TB] FAIL b2b_nwrites: got %0d required %0d", obs_addr.size(), exp_addr.size());
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("[TB] FAIL b2b_write%0d: got %h@%0d required %h@%0d", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    prog_bytes.delete();
    for (int k = 0; k < 4; k++) add_word(rand_word());
    model_load();
    drive_program(2, 2);
    n_checks++;
    if (obs_addr.size() !== exp_addr.size()) $display("[TB] FAIL ovf_nwrites: got %0d required %0d", obs_addr.size(), exp_addr.size());
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("[TB] FAIL ovf_write%0d: got %h@%0d required %h@%0d", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
      else n_pass++;
    end
    n_checks++;
    if ({error, load_done} !== 2'b10 || mem_addr !== 2'd3 || word_count !== 3'd4)
      $display("[TB] FAIL ovf_status: got err/done=%b addr=%0d cnt=%0d required 10 addr=3 cnt=4", {error, load_done}, mem_addr, word_count);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [7:0] b[4];
    do_reset();
    pulse_start();
    send_byte(8'hA1, 1, 1);
    send_byte(8'hB2, 1, 1);
    tick(99);
    n_checks++;
    if ({busy, error} !== 2'b10) $display("[TB] FAIL to_before: got busy/err=%b required 10", {busy, error});
    else n_pass++;
    tick(1);
    n_checks++;
    if ({busy, error, obs_addr.size() == 0} !== 3'b011) $display("[TB] FAIL to_expire: got busy/err/nowrite=%b required 011", {busy, error, obs_addr.size() == 0});
    else n_pass++;

    // With no byte of the current word received, ticks never time out.
    do_reset();
    pulse_start();
    tick(150);
    n_checks++;
    if ({busy, error} !== 2'b10) $display("[TB] FAIL to_idle_word: got busy/err=%b required 10", {busy, error});
    else n_pass++;

    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    send_byte(b[0], 1, 1);
    tick(99);
    s_tick = 1'b1; d_in = b[1]; rx_done = 1'b1;
    @(posedge clk); #1;
    s_tick = 1'b0; rx_done = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, error} !== 2'b10) $display("[TB] FAIL to_tie: got busy/err=%b required 10", {busy, error});
    else n_pass++;
    send_byte(b[2], 1, 1);
    send_byte(b[3], 1, 1);
    prog_bytes = '{b[0], b[1], b[2], b[3], 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    model_load();
    for (int i = 4; i < 8; i++) send_byte(prog_bytes[i], 1, 1);
    wait_idle(100);
    n_checks++;
    if (obs_data.size() !== 2 || obs_data[0] !== exp_data[0] || load_done !== 1'b1)
      $display("[TB] FAIL to_tie_word: got n=%0d done=%b word0=%h required n=2 done=1 word0=%h",
               obs_data.size(), load_done, (obs_data.size() > 0) ? obs_data[0] : 32'h0, exp_data[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if ({mem_we, busy, load_done, error} !== 4'b0000 || mem_addr !== '0 || word_count !== '0)
      $display("[TB] FAIL midrst_outputs: got flags=%b addr=%0d cnt=%0d required 0", {mem_we, busy, load_done, error}, mem_addr, word_count);
    else n_pass++;
    prog_bytes.delete();
    add_word(rand_word()); add_word(HALT);
    model_load();
    drive_program(1, 2);
    n_checks++;
    if (obs_addr.size() !== 2 || obs_addr[0] !== 0 || obs_data[0] !== exp_data[0])
      $display("[TB] FAIL midrst_word: got n=%0d word0=%h required n=2 word0=%h@0",
               obs_addr.size(), (obs_data.size() > 0) ? obs_data[0] : 32'h0, exp_data[0]);
    else n_pass++;
  endtask

  task automatic test_rearm();
    do_reset();
    prog_bytes.delete();
    add_word(HALT);
    drive_program(1, 2);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1, 1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_addr.size() !== 1 || load_done !== 1'b1) $display("[TB] FAIL rearm_ignore: got writes=%0d done=%b required 1 1", obs_addr.size(), load_done);
    else n_pass++;
    pulse_start();
    n_checks++;
    if ({busy, load_done} !== 2'b10 || mem_addr !== '0 || word_count !== '0)
      $display("[TB] FAIL rearm_start: got busy/done=%b addr=%0d cnt=%0d required 10 0 0", {busy, load_done}, mem_addr, word_count);
    else n_pass++;
    for (int i = 0; i < 4; i++) send_byte(8'hFF, 1, 1);
    wait_idle(50);
    n_checks++;
    if (load_done !== 1'b1 || word_count !== 3'd1) $display("[TB] FAIL rearm_finish: got done=%b cnt=%0d required 1 1", load_done, word_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide_rx();
    test_random_loads();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_reset_mid_word();
    test_rearm();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
